// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster counters, syncs, blanking and line/frame strobes; `define VGA_PIXEL_DIV2_EN for a pixel tick every second clk
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_ctrl: H_TOTAL/V_TOTAL exceed counter widths");
  end
  typedef enum logic [2:0] {IDLE, ACTIVE, FRONT, SYNC, BACK} state_t;
  state_t hstate, vstate, hst_n, vst_n;
  logic [10:0] hn;
  logic [9:0]  vn;
  logic running, tick, hwrap;
  function automatic state_t axis_state(input logic [10:0] c, input int a, input int fp, input int sy);
    return c < 11'(a) ? ACTIVE : c < 11'(a + fp) ? FRONT : c < 11'(a + fp + sy) ? SYNC : BACK;
  endfunction
  assign running = hstate != IDLE;
`ifdef VGA_PIXEL_DIV2_EN
  logic toggle;
  // leaving IDLE is always a tick so 0/0 appears immediately, then holds for a second clk
  assign tick = !running || toggle;
  always_ff @(posedge clk)
    if (rst || !en) toggle <= 1'b0;
    else toggle <= running && !toggle;
`else
  assign tick = 1'b1;
`endif
  // outputs are decoded from the next counts so they line up with the registered counters
  always_comb begin
    hwrap = hcount == 11'(H_TOTAL - 1);
    hn = (!running || hwrap) ? '0 : hcount + 11'd1;
    vn = !running ? '0 : !hwrap ? vcount : (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 10'd1;
    hst_n = axis_state(hn, H_ACTIVE, H_FP, H_SYNC);
    vst_n = axis_state({1'b0, vn}, V_ACTIVE, V_FP, V_SYNC);
  end
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      hstate      <= IDLE;
      vstate      <= IDLE;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= !H_POL;
      vsync       <= !V_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      hstate      <= hst_n;
      vstate      <= vst_n;
      hcount      <= hn;
      vcount      <= vn;
      hsync       <= (hst_n == SYNC) ? H_POL : !H_POL;
      vsync       <= (vst_n == SYNC) ? V_POL : !V_POL;
      video_on    <= hst_n == ACTIVE && vst_n == ACTIVE;
      line_start  <= hn == '0;
      frame_start <= hn == '0 && vn == '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench; default-timing DUT plus a small-raster DUT for whole-frame checks
module tb_vga_timing_ctrl;
  logic clk = 1'b0, rst, en;
  logic [10:0] d_h, s_h;
  logic [9:0]  d_v, s_v;
  logic d_hs, d_vs, d_vo, d_ls, d_fs;
  logic s_hs, s_vs, s_vo, s_ls, s_fs;
  int n_chk = 0, n_pass = 0;
  int cnt_hs = 0, cnt_fs = 0, cnt_vs = 0;
  logic win = 1'b0;
  logic [25:0] q_d[$], q_s[$];
  logic [10:0] dh = '0, sh = '0;
  logic [9:0]  dv = '0, sv = '0;
  logic drun = 1'b0, srun = 1'b0;

  always #5 clk = ~clk;

  vga_timing_ctrl dut_def (
    .clk(clk), .rst(rst), .en(en), .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs),
    .video_on(d_vo), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b1)
  ) dut_sml (
    .clk(clk), .rst(rst), .en(en), .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
    .video_on(s_vo), .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic adv(input logic r, input logic e, input int ht, input int vt,
                     input logic [10:0] h, input logic [9:0] v, input logic run,
                     output logic [10:0] nh, output logic [9:0] nv, output logic nrun);
    nh = '0; nv = '0; nrun = 1'b0;
    if (!r && e) begin
      nrun = 1'b1;
      if (run) begin
        nh = (int'(h) == ht - 1) ? 11'd0 : h + 11'd1;
        nv = (int'(h) != ht - 1) ? v : (int'(v) == vt - 1) ? 10'd0 : v + 10'd1;
      end
    end
  endtask

  function automatic logic [25:0] exp_of(input logic [10:0] h, input logic [9:0] v, input logic run,
                                          input int ha, input int hf, input int hw,
                                          input int va, input int vf, input int vw,
                                          input logic hp, input logic vp);
    logic hin, vin, ls;
    hin = run && int'(h) >= ha + hf && int'(h) < ha + hf + hw;
    vin = run && int'(v) >= va + vf && int'(v) < va + vf + vw;
    ls = run && h == 11'd0;
    return {h, v, hin ? hp : !hp, vin ? vp : !vp, run && int'(h) < ha && int'(v) < va, ls, ls && v == 10'd0};
  endfunction

  task automatic cyc(input logic r, input logic e);
    rst = r;
    en = e;
    @(posedge clk);
    adv(r, e, 1040, 666, dh, dv, drun, dh, dv, drun);
    adv(r, e, 35, 17, sh, sv, srun, sh, sv, srun);
    q_d.push_back(exp_of(dh, dv, drun, 800, 56, 120, 600, 37, 6, 1'b1, 1'b1));
    q_s.push_back(exp_of(sh, sv, srun, 20, 4, 6, 10, 2, 3, 1'b0, 1'b1));
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (q_d.size() > 0) check("def_outs", {6'd0, d_h, d_v, d_hs, d_vs, d_vo, d_ls, d_fs}, {6'd0, q_d.pop_front()});
    if (q_s.size() > 0) check("sml_outs", {6'd0, s_h, s_v, s_hs, s_vs, s_vo, s_ls, s_fs}, {6'd0, q_s.pop_front()});
    if (win) begin
      cnt_hs += int'(d_hs);
      cnt_fs += int'(s_fs);
      cnt_vs += int'(s_vs);
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    repeat (3) cyc(1'b1, 1'b1);
    win = 1'b1;
    repeat (1785) cyc(1'b0, 1'b1);
    win = 1'b0;
    check("hsync_width", cnt_hs, 120);
    check("sml_frame_starts", cnt_fs, 3);
    check("sml_vsync_cycles", cnt_vs, 315);
    repeat (300) cyc(1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b0);
    repeat (1200) cyc(1'b0, 1'b1);
    repeat (5) cyc(1'b1, 1'b1);
    repeat (700) cyc(1'b0, 1'b1);
    repeat (5) cyc(1'b1, 1'b0);
    repeat (50) cyc(1'b0, 1'b1);
    repeat (600) cyc($urandom_range(0, 49) == 0, $urandom_range(0, 15) != 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
